// File: rtl/dm_pkg.sv
// Shared encodings for the multi-cycle data memory: access sizes, FSM states
// and the byte-count helper used by the range check.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // The illegal size reports 4 bytes; it is rejected on its own anyway.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dm_byte_array.sv
// Byte-wide storage with a 4-lane big-endian word port: lane 3 (bits 31:24)
// maps to the lowest byte address of the word. Contents are never reset.
module dm_byte_array #(
    parameter int MEM_BYTES = 128,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-3:0] word_idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we[3-l]) begin
                mem[{word_idx, 2'(l)}] <= wdata[31-8*l -: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int l = 0; l < 4; l++) begin
            rdata[31-8*l -: 8] = mem[{word_idx, 2'(l)}];
        end
    end

endmodule

// File: rtl/data_mem_mc.sv
// Multi-cycle big-endian data memory: valid/ready request, fixed latency,
// byte/half/word access with extension and error flagging for bad accesses.
module data_mem_mc
    import dm_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t      state;
    logic [CW-1:0] count;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [1:0]  off;
    logic [32:0] last_ok;
    logic        acc_err;
    logic        commit;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign off = addr_q[1:0];

    // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
    assign last_ok = 33'(MEM_BYTES) - 33'(nbytes(size_q));
    assign acc_err = (size_q == 2'b11)
                   | ((size_q == SZ_HALF) & addr_q[0])
                   | ((size_q == SZ_WORD) & (|addr_q[1:0]))
                   | ({1'b0, addr_q} > last_ok);

    assign commit = (state == WAIT) && (count == '0) && !acc_err && wr_q;

    assign rd_byte = 8'(rd_word >> (5'd24 - {off, 3'b000}));
    assign rd_half = 16'(rd_word >> (5'd16 - {off[1], 4'b0000}));

    always_comb begin
        lane_mask  = 4'b0000;
        lane_wdata = wdata_q;
        load_data  = '0;
        case (size_q)
            SZ_BYTE: begin
                lane_mask  = 4'b1000 >> off;
                lane_wdata = {4{wdata_q[7:0]}};
                load_data  = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                lane_mask  = 4'b1100 >> {off[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
                load_data  = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            SZ_WORD: begin
                lane_mask  = 4'b1111;
                load_data  = rd_word;
            end
            default: begin
                lane_mask  = 4'b0000;
            end
        endcase
    end

    dm_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_array (
        .clk      (clk),
        .we       (commit ? lane_mask : 4'b0000),
        .word_idx (addr_q[AW-1:2]),
        .wdata    (lane_wdata),
        .rdata    (rd_word)
    );

    // Only the captured request drives the access; req_* is ignored outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        count     <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err;
                        resp_rdata <= (acc_err || wr_q) ? 32'd0 : load_data;
                        state      <= RESP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mc.sv
// Directed bench for data_mem_mc: a byte-array reference model predicts each
// response into a scoreboard queue, compared when the DUT answers.
module tb_data_mem_mc;

    localparam int MEM = 128;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_ready, resp_err;

    logic        bv[2], brdy[2], bw[2], bu[2], brv[2], brr[2], berr[2];
    logic [1:0]  bs[2];
    logic [31:0] ba[2], bd[2], brd[2];

    int   cyc = 0;
    int   accept_cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    exp_t sb[$];
    logic [7:0] model_mem [MEM];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_mc #(.MEM_BYTES(MEM), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_mc #(.MEM_BYTES(MEM), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(bv[0]), .req_ready(brdy[0]), .req_write(bw[0]),
        .req_size(bs[0]), .req_unsigned(bu[0]), .req_addr(ba[0]),
        .req_wdata(bd[0]), .resp_valid(brv[0]), .resp_ready(brr[0]),
        .resp_rdata(brd[0]), .resp_err(berr[0])
    );

    data_mem_mc #(.MEM_BYTES(MEM), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(bv[1]), .req_ready(brdy[1]), .req_write(bw[1]),
        .req_size(bs[1]), .req_unsigned(bu[1]), .req_addr(ba[1]),
        .req_wdata(bd[1]), .resp_valid(brv[1]), .resp_ready(brr[1]),
        .resp_rdata(brd[1]), .resp_err(berr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: big-endian byte array, updates memory for legal stores.
    function automatic exp_t predict(input logic w, input logic [1:0] s, input logic u,
                                     input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          n;
        logic [31:0] v;
        n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        e.err = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
                || ({32'b0, a} > 64'(MEM - n));
        e.rdata = 32'd0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < n; i++) model_mem[int'(a) + i] = d[8*(n-1-i) +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = {v[23:0], model_mem[int'(a) + i]};
                if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic w, input logic [1:0] s, input logic u,
                                 input logic [31:0] a, input logic [31:0] d, input bit track);
        int n = 0;
        req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        accept_cyc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        if (track) sb.push_back(predict(w, s, u, a, d));
    endtask

    task automatic waitResp();
        int n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", resp_valid, 1);
        if (resp_valid) chk("latency", cyc - accept_cyc, LAT);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_err"}, resp_err, e.err);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ready_after_hs", req_ready, 1);
        chk("valid_after_hs", resp_valid, 0);
    endtask

    task automatic access(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        applyStimulus(w, s, u, a, d, 1);
        waitResp();
        checkOutput(tag);
        handshake();
    endtask

    function automatic logic [31:0] b2bData(input int i);
        return 32'hC0DE_0000 | 32'(i * 17);
    endfunction

    // Held-high handshakes: accept, LATENCY wait edges, one RESP edge, one IDLE edge.
    task automatic runB2B(input int k, input int lat);
        exp_t q[$];
        exp_t e;
        int   sent = 0, got = 0, last = -1, n = 0;
        brr[k] = 1'b1;
        while (got < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (brv[k]) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("b2b_rdata", brd[k], e.rdata);
                    chk("b2b_err", berr[k], e.err);
                end else begin
                    chk("b2b_spurious", q.size(), 1);
                end
                if (last >= 0) chk("b2b_period", cyc - last, lat + 2);
                last = cyc;
                got++;
            end
            bv[k] = (sent < 8);
            bw[k] = (sent < 4);
            bs[k] = 2'b10;
            bu[k] = 1'b0;
            ba[k] = 32'((sent % 4) * 4);
            bd[k] = b2bData(sent);
            if (brdy[k] && sent < 8) begin
                e.rdata = (sent < 4) ? 32'd0 : b2bData(sent - 4);
                e.err   = 1'b0;
                q.push_back(e);
                sent++;
            end
        end
        chk("b2b_count", got, 8);
        brr[k] = 1'b0;
        bv[k]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bv[k] = 1'b0; bw[k] = 1'b0; bu[k] = 1'b0; bs[k] = 2'b00;
            ba[k] = '0; bd[k] = '0; brr[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] word store/load");
        access(1, 2'b10, 0, 32'h10, 32'h1234_5678, "t1_sw");
        access(0, 2'b10, 0, 32'h10, 32'h0, "t1_lw");

        $display("[TB] sub-word access and extension");
        access(0, 2'b00, 0, 32'h12, 32'h0, "t2_lb");
        access(0, 2'b01, 0, 32'h10, 32'h0, "t2_lh");
        access(1, 2'b00, 0, 32'h13, 32'hFFFF_FF80, "t2_sb");
        access(0, 2'b00, 0, 32'h13, 32'h0, "t2_lb_neg");
        access(0, 2'b00, 1, 32'h13, 32'h0, "t2_lbu");
        access(1, 2'b01, 0, 32'h14, 32'h1234_BEEF, "t2_sh");
        access(0, 2'b01, 0, 32'h14, 32'h0, "t2_lh_neg");
        access(0, 2'b01, 1, 32'h14, 32'h0, "t2_lhu");
        access(0, 2'b10, 0, 32'h14, 32'h0, "t2_lw14");

        $display("[TB] error cases");
        access(1, 2'b10, 0, 32'h7C, 32'hCAFE_F00D, "t3_sw7c");
        access(1, 2'b00, 0, 32'h7F, 32'h0000_00A5, "t3_sb7f");
        access(0, 2'b10, 0, 32'h02, 32'h0, "t3_lw_mis");
        access(0, 2'b01, 0, 32'h11, 32'h0, "t3_lh_mis");
        access(0, 2'b11, 0, 32'h00, 32'h0, "t3_size11");
        access(0, 2'b10, 0, MEM - 2, 32'h0, "t3_lw_end");
        access(0, 2'b10, 0, MEM, 32'h0, "t3_lw_oor");
        access(0, 2'b01, 0, 32'hFFFF_FFFE, 32'h0, "t3_lh_wrap");
        access(1, 2'b10, 0, 32'h7E, 32'hFFFF_FFFF, "t3_sw_mis");
        access(1, 2'b11, 0, 32'h7C, 32'h0, "t3_st_size11");
        access(0, 2'b10, 0, 32'h7C, 32'h0, "t3_lw7c");
        access(0, 2'b00, 1, 32'h7F, 32'h0, "t3_lbu7f");

        $display("[TB] response back-pressure");
        applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 1);
        waitResp();
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0]; req_write = 1'b1; req_size = 2'b10;
            req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("t4_hold_valid", resp_valid, 1);
            chk("t4_hold_rdata", resp_rdata, sb[0].rdata);
            chk("t4_hold_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        checkOutput("t4_resp");
        handshake();
        access(0, 2'b10, 0, 32'h10, 32'h0, "t4_recheck");

        $display("[TB] reset during access");
        access(1, 2'b10, 0, 32'h20, 32'h1122_3344, "t5_pre");
        applyStimulus(1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_req_ready", req_ready, 1);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_rdata", resp_rdata, 0);
        chk("t5_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(0, 2'b10, 0, 32'h20, 32'h0, "t5_load");

        $display("[TB] back-to-back streams");
        runB2B(0, 1);
        runB2B(1, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
